// File: rtl/pio_avalon_gen2.sv
// Avalon-MM GPIO: per-bit direction, 2-flop input sync, atomic set/clear of outputs.
// Define PIO_EDGE_IRQ_EN to build edge capture, IRQ mask and the level interrupt.
module pio_avalon_gen2 #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_OUT = '0,
  parameter logic [31:0] RESET_DIR = '0,
  parameter int          EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_OUT = RESET_OUT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_DIR = RESET_DIR[WIDTH-1:0];

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out, dir, s1, sync, rd_w;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RST_OUT;
      dir      <= RST_DIR;
    end else if (wr) begin
      case (address)
        3'd0:    data_out <= wd;
        3'd1:    dir      <= wd;
        3'd4:    data_out <= data_out | wd;
        3'd5:    data_out <= data_out & ~wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      sync <= '0;
    end else begin
      s1   <= in_port;
      sync <= s1;
    end
  end

  assign out_port = data_out;
  assign oe       = dir;

`ifdef PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] prev, det, edge_cap, mask, clr;

  always_comb begin
    det = '0;
    case (EDGE_TYPE)
      0:       det = sync & ~prev;
      1:       det = ~sync & prev;
      default: det = sync ^ prev;
    endcase
  end

  assign clr = (wr && address == 3'd3) ? wd : '0;

  // Detect is OR'd in after the clear so a same-cycle edge survives a W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      edge_cap <= '0;
      mask     <= '0;
    end else begin
      prev     <= sync;
      edge_cap <= (edge_cap & ~clr) | det;
      if (wr && address == 3'd2) mask <= wd;
    end
  end

  assign irq = |(edge_cap & mask);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_w = '0;
    case (address)
      3'd0:    rd_w = (sync & ~dir) | (data_out & dir);
      3'd1:    rd_w = dir;
`ifdef PIO_EDGE_IRQ_EN
      3'd2:    rd_w = mask;
      3'd3:    rd_w = edge_cap;
`endif
      default: rd_w = '0;
    endcase
  end

  always_comb begin
    readdata            = '0;
    readdata[WIDTH-1:0] = rd_w;
  end

endmodule
